// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I subset control path.
// Holds opcode constants, the FSM state encoding, the mux/select codes driven
// to the datapath (also used by the immediate generator and ALU decoder), and
// the per-state control word decode used by the main controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10} imm_src_t;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALU = 2'b10} result_src_t;
  typedef enum logic [1:0] {TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_TIMEOUT = 2'b10} trap_cause_t;

  // Registered control word; ir_write/pc_write are not here because they
  // depend on same-cycle inputs (mem_ready, zero).
  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        reg_write;
    imm_src_t    imm_src;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
    result_src_t result_src;
  } ctrl_t;

  // Control word for the state about to be entered. opcode only matters in
  // MEMADR, where it selects the load or store immediate format.
  function automatic ctrl_t state_ctrl(state_t s, logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_B;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        c.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_MEMDATA;
        c.reg_write  = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_I;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALU_SUB;
        c.result_src = RES_ALUOUT;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts cycles an access has been stalled.
// Ports: clk, rst_n (async active-low), clr (restart count, wins over run),
// run (access pending and not completing this cycle), expired (the current
// stalled cycle is the last one allowed).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned TMR_W       = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] SAT   = TMR_W'(TIMEOUT_CYC);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (run && (count_q != SAT)) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

  assign expired = run && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle RV32I subset datapath (lw, sw, beq,
// R-type, I-type ALU) sharing one ALU and one memory port.
// Inputs : clk, rst_n (async active-low), opcode/funct3 from IR, ALU zero,
//          mem_ready (memory completes current access this cycle).
// Outputs: mem_req/mem_we/adr_src memory control, ir_write/pc_write/reg_write
//          enables, imm_src, alu_src_a/b, alu_op, result_src selects, and the
//          sticky trap flag with trap_cause (01 illegal opcode, 10 timeout).
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned TMR_W       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_t      state_q, state_d;
  ctrl_t       ctrl_q;
  logic        trap_q;
  trap_cause_t cause_q, cause_d;
  logic        acc_done;
  logic        expired;

  // An access only completes while the request is actually driven; this keeps
  // the reset-release cycle (FETCH state, outputs still 0) from advancing.
  assign acc_done = ctrl_q.mem_req & mem_ready;

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_d != state_q),
    .run    (ctrl_q.mem_req & ~mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = TC_NONE;
    case (state_q)
      S_FETCH: begin
        if (acc_done) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH: begin
            if (funct3 == F3_BEQ) begin
              state_d = S_BEQ;
            end else begin
              state_d = S_TRAP;
              cause_d = TC_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (acc_done) begin
          state_d = S_MEMWB;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (acc_done) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so outputs stay 0 through
  // reset and take the FETCH values on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, opcode);
      if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  assign ir_write   = (state_q == S_FETCH) & acc_done;
  assign pc_write   = ir_write | ((state_q == S_BEQ) & zero);
  assign mem_req    = ctrl_q.mem_req;
  assign mem_we     = ctrl_q.mem_we;
  assign adr_src    = ctrl_q.adr_src;
  assign reg_write  = ctrl_q.reg_write;
  assign imm_src    = ctrl_q.imm_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: a directed vector table, hand-built corner
// sequences, and random instruction streams whose expected per-cycle outputs
// are generated from instruction step scripts.
module tb_multicycle_ctrl;

  localparam int unsigned TOUT = 4;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
  logic       trap;
  logic [1:0] trap_cause;

  multicycle_ctrl #(.TIMEOUT_CYC(TOUT), .TMR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .trap(trap), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    outs_t      exp;
  } vec_t;

  vec_t       q[$];
  vec_t       tbl[11];
  int         n_chk = 0;
  int         n_fail = 0;
  string      tname;
  bit         tr;
  logic [1:0] c;

  function automatic outs_t mk(input logic req, we, adr, irw, pcw, rw,
                               input logic [1:0] imm, a, b, op, rs,
                               input logic tp, input logic [1:0] tc);
    outs_t o;
    o.mem_req = req; o.mem_we = we; o.adr_src = adr; o.ir_write = irw;
    o.pc_write = pcw; o.reg_write = rw; o.imm_src = imm; o.alu_src_a = a;
    o.alu_src_b = b; o.alu_op = op; o.result_src = rs; o.trap = tp;
    o.trap_cause = tc;
    return o;
  endfunction

  function automatic outs_t actual();
    return mk(mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_src,
              alu_src_a, alu_src_b, alu_op, result_src, trap, trap_cause);
  endfunction

  // Expected outputs of each instruction step
  function automatic outs_t e_fetch(input logic rdy);
    return mk(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 2'b00);
  endfunction
  function automatic outs_t e_decode();
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic outs_t e_memadr(input logic st);
    return mk(0, 0, 0, 0, 0, 0, st ? 2'b01 : 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic outs_t e_mem(input logic we);
    return mk(1, we, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic outs_t e_memwb();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 2'b00);
  endfunction
  function automatic outs_t e_exec(input logic imm);
    return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, imm ? 2'b01 : 2'b00, 2'b10, 2'b00, 0, 2'b00);
  endfunction
  function automatic outs_t e_aluwb();
    return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic outs_t e_beq(input logic z);
    return mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 0, 2'b00);
  endfunction
  function automatic outs_t e_trap(input logic [1:0] tc);
    return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, tc);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string what, input outs_t act, input outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s t=%0t: got %b, required %b", tname, what, $time, act, exp);
    end
  endtask

  task automatic push(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                      input logic rdy, input outs_t e);
    vec_t v;
    v.opcode = opc; v.funct3 = f3; v.zero = z; v.mem_ready = rdy; v.exp = e;
    q.push_back(v);
  endtask

  // One memory access: kind 0 fetch, 1 read, 2 write. waits >= TOUT stalls
  // for the whole allowed window and ends in a timeout.
  task automatic add_access(input int waits, input logic [6:0] opc, input logic [2:0] f3,
                            input int kind, output bit timed_out);
    int n;
    logic [6:0] o;
    n = (waits >= int'(TOUT)) ? int'(TOUT) : waits;
    timed_out = (waits >= int'(TOUT));
    for (int i = 0; i < n; i++) begin
      o = (kind == 0) ? 7'($urandom) : opc;
      push(o, f3, rb(), 1'b0, (kind == 0) ? e_fetch(1'b0) : e_mem(kind == 2));
    end
    if (!timed_out) begin
      o = (kind == 0) ? 7'($urandom) : opc;
      push(o, f3, rb(), 1'b1, (kind == 0) ? e_fetch(1'b1) : e_mem(kind == 2));
    end
  endtask

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 illegal opcode (ill), 6 branch funct3!=0
  task automatic add_instr(input int kind, input int wf, input int wm, input logic z,
                           input logic [6:0] ill, output bit trapped, output logic [1:0] cause);
    logic [6:0] opc;
    logic [2:0] f3;
    bit         to;
    trapped = 0;
    cause   = 2'b00;
    f3      = 3'($urandom);
    case (kind)
      0: opc = OP_LW;
      1: opc = OP_SW;
      2: opc = OP_R;
      3: opc = OP_I;
      4: begin opc = OP_BR; f3 = 3'b000; end
      5: opc = ill;
      default: begin opc = OP_BR; f3 = 3'($urandom_range(1, 7)); end
    endcase
    add_access(wf, opc, f3, 0, to);
    if (to) begin
      trapped = 1; cause = 2'b10;
      return;
    end
    push(opc, f3, rb(), rb(), e_decode());
    case (kind)
      0, 1: begin
        push(opc, f3, rb(), rb(), e_memadr(kind == 1));
        add_access(wm, opc, f3, (kind == 1) ? 2 : 1, to);
        if (to) begin
          trapped = 1; cause = 2'b10;
          return;
        end
        if (kind == 0) push(opc, f3, rb(), rb(), e_memwb());
      end
      2, 3: begin
        push(opc, f3, rb(), rb(), e_exec(kind == 3));
        push(opc, f3, rb(), rb(), e_aluwb());
      end
      4: push(opc, f3, z, rb(), e_beq(z));
      default: begin trapped = 1; cause = 2'b01; end
    endcase
  endtask

  task automatic add_trap(input int n, input logic [1:0] tc);
    for (int i = 0; i < n; i++) push(7'($urandom), 3'($urandom), rb(), rb(), e_trap(tc));
  endtask

  task automatic drive(input vec_t v);
    opcode = v.opcode; funct3 = v.funct3; zero = v.zero; mem_ready = v.mem_ready;
  endtask

  task automatic run_q();
    vec_t v;
    int   k;
    k = 0;
    while (q.size() > 0) begin
      v = q.pop_front();
      @(negedge clk);
      drive(v);
      #1;
      check($sformatf("cycle%0d", k), actual(), v.exp);
      k++;
    end
  endtask

  // Asynchronous reset mid-cycle, held across an edge, released on a negedge;
  // the release cycle itself must still show all outputs 0.
  task automatic do_reset();
    #2;
    mem_ready = 1'b1; zero = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_async", actual(), '0);
    @(negedge clk);
    #1;
    check("reset_held", actual(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", actual(), '0);
  endtask

  initial begin
    rst_n = 1'b1; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    tname = "reset";
    do_reset();

    // lw with mem_ready always 1, then beq taken and beq not taken
    tbl[0]  = '{OP_LW, 3'b010, 1'b0, 1'b1, e_fetch(1'b1)};
    tbl[1]  = '{OP_LW, 3'b010, 1'b0, 1'b1, e_decode()};
    tbl[2]  = '{OP_LW, 3'b010, 1'b0, 1'b1, e_memadr(1'b0)};
    tbl[3]  = '{OP_LW, 3'b010, 1'b0, 1'b1, e_mem(1'b0)};
    tbl[4]  = '{OP_LW, 3'b010, 1'b0, 1'b1, e_memwb()};
    tbl[5]  = '{OP_BR, 3'b000, 1'b1, 1'b1, e_fetch(1'b1)};
    tbl[6]  = '{OP_BR, 3'b000, 1'b1, 1'b1, e_decode()};
    tbl[7]  = '{OP_BR, 3'b000, 1'b1, 1'b1, e_beq(1'b1)};
    tbl[8]  = '{OP_BR, 3'b000, 1'b0, 1'b1, e_fetch(1'b1)};
    tbl[9]  = '{OP_BR, 3'b000, 1'b0, 1'b1, e_decode()};
    tbl[10] = '{OP_BR, 3'b000, 1'b0, 1'b1, e_beq(1'b0)};
    tname = "table";
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("row%0d", i), actual(), tbl[i].exp);
    end

    tname = "sw_delayed";
    add_instr(1, 0, 3, 1'b0, 7'h00, tr, c);
    add_instr(2, 0, 0, 1'b0, 7'h00, tr, c);
    run_q();

    tname = "fetch_ready_at_limit";
    add_instr(3, int'(TOUT) - 1, 0, 1'b0, 7'h00, tr, c);
    run_q();

    tname = "reset_mid_memread";
    add_access(0, OP_LW, 3'b010, 0, tr);
    push(OP_LW, 3'b010, 1'b0, 1'b0, e_decode());
    push(OP_LW, 3'b010, 1'b0, 1'b0, e_memadr(1'b0));
    push(OP_LW, 3'b010, 1'b0, 1'b0, e_mem(1'b0));
    run_q();
    do_reset();
    add_instr(0, 0, 0, 1'b0, 7'h00, tr, c);
    run_q();

    tname = "illegal_opcode";
    add_instr(5, 0, 0, 1'b0, 7'h7f, tr, c);
    add_trap(20, c);
    run_q();
    do_reset();

    tname = "beq_bad_funct3";
    add_instr(6, 0, 0, 1'b0, 7'h00, tr, c);
    add_trap(4, c);
    run_q();
    do_reset();

    tname = "fetch_timeout";
    add_instr(2, int'(TOUT), 0, 1'b0, 7'h00, tr, c);
    add_trap(6, c);
    run_q();
    do_reset();

    tname = "memread_timeout";
    add_instr(0, 1, int'(TOUT), 1'b0, 7'h00, tr, c);
    add_trap(5, c);
    run_q();
    do_reset();

    tname = "random";
    for (int it = 0; it < 150; it++) begin
      int kind, k, wf, wm;
      logic [6:0] ill;
      k = int'($urandom_range(0, 11));
      kind = (k < 10) ? k / 2 : k - 5;
      wf = ($urandom_range(0, 11) == 0) ? int'(TOUT) : int'($urandom_range(0, TOUT - 1));
      wm = ($urandom_range(0, 7) == 0) ? int'(TOUT) : int'($urandom_range(0, TOUT - 1));
      do ill = 7'($urandom); while (ill inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR});
      add_instr(kind, wf, wm, rb(), ill, tr, c);
      if (tr) add_trap(int'($urandom_range(1, 4)), c);
      run_q();
      if (tr) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
